// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants used by the fetch path.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    SQUASH
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, a single-entry
// instruction buffer toward decode, and redirect handling with stale-response squash.
module fetch_sequencer
  import rv32_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_addr,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [ILEN-1:0]  inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] fetch_pc
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             buf_valid_q, buf_valid_d;
  logic [ILEN-1:0]  buf_data_q, buf_data_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic             req_hs;
  logic             inst_hs;

  function automatic logic [WIDTH-1:0] align_pc(input logic [WIDTH-1:0] a);
    return a & ~WIDTH'(3);
  endfunction

  function automatic logic [WIDTH-1:0] incr_pc(input logic [WIDTH-1:0] a);
    return a + WIDTH'(4);
  endfunction

  // A request is only offered into an empty buffer, so a response never finds it occupied.
  assign imem_req_valid = !rst && (state_q == REQ) && !buf_valid_q;
  assign imem_req_addr  = pc_q;
  assign fetch_pc       = pc_q;
  assign inst_valid     = buf_valid_q;
  assign inst_data      = buf_data_q;
  assign inst_pc        = buf_pc_q;

  assign req_hs  = imem_req_valid && imem_req_ready;
  assign inst_hs = buf_valid_q && inst_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q && !inst_hs;
    buf_data_d  = buf_data_q;
    buf_pc_d    = buf_pc_q;
    if (redirect_valid) begin
      pc_d        = align_pc(redirect_addr);
      buf_valid_d = 1'b0;
      case (state_q)
        REQ:     state_d = req_hs ? SQUASH : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : SQUASH;
        SQUASH:  state_d = imem_rsp_valid ? REQ : SQUASH;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (req_hs) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            buf_valid_d = 1'b1;
            buf_data_d  = imem_rsp_data;
            buf_pc_d    = pc_q;
            pc_d        = incr_pc(pc_q);
            state_d     = REQ;
          end
        end
        SQUASH: begin
          if (imem_rsp_valid) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_ADDR;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // A response while no request is outstanding means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (rst) !(state_q == REQ && imem_rsp_valid))
    else $error("imem_rsp_valid with no request outstanding");

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against an instruction-stream model.
module tb_fetch_sequencer;
  import rv32_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc, fetch_pc;

  logic        b_req_valid;
  logic [31:0] b_req_addr;
  logic        b_rsp_valid = 1'b0;
  logic        b_inst_valid;
  logic [31:0] b_inst_data, b_inst_pc, b_fetch_pc;

  fetch_sequencer #(.WIDTH(32), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc)
  );

  fetch_sequencer #(.WIDTH(32), .RESET_ADDR(RST_B)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(NOP_INSN),
    .redirect_valid(1'b0), .redirect_addr(32'h0),
    .inst_valid(b_inst_valid), .inst_ready(1'b1), .inst_data(b_inst_data), .inst_pc(b_inst_pc),
    .fetch_pc(b_fetch_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs and memory / stream model state.
  logic        drv_rst = 1'b1, drv_ready = 1'b1, drv_irdy = 1'b1, drv_redir = 1'b0;
  logic [31:0] drv_raddr = '0;
  bit          rdy_rand = 0, irdy_rand = 0, redir_rand = 0, lat_rand = 0, rst_rand = 0;
  int          lat_cfg = 1;
  bit          pend = 0, b_pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = RST_A;
  int          cyc = 0, n_deliv = 0;
  int          hs_cyc[$];
  logic [31:0] b_addrs[$];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic tick();
    logic req_hs, inst_hs;
    @(negedge clk);
    if (rdy_rand)   drv_ready = ($urandom_range(0, 3) != 0);
    if (irdy_rand)  drv_irdy  = ($urandom_range(0, 2) != 0);
    if (redir_rand) begin
      drv_redir = ($urandom_range(0, 15) == 0);
      drv_raddr = $urandom;
    end
    if (rst_rand)   drv_rst = ($urandom_range(0, 499) == 0);
    rst            = drv_rst;
    imem_req_ready = drv_ready;
    inst_ready     = drv_irdy;
    redirect_valid = drv_redir;
    redirect_addr  = drv_raddr;
    imem_rsp_valid = pend && (pend_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    b_rsp_valid    = b_pend;
    #3;
    req_hs  = imem_req_valid && imem_req_ready;
    inst_hs = inst_valid && inst_ready;
    if (rst) begin
      exp_pc = RST_A;
      pend   = 0;
      b_pend = 0;
    end else begin
      chk_eq("fetch_pc_eq_req_addr", fetch_pc, imem_req_addr);
      if (inst_valid) chk_eq("req_blocked_by_buf", imem_req_valid, 1'b0);
      if (req_hs) chk_eq("req_addr", imem_req_addr, exp_pc);
      if (inst_hs) begin
        chk_eq("inst_pc", inst_pc, exp_pc);
        chk_eq("inst_data", inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
        hs_cyc.push_back(cyc);
      end
      if (redirect_valid) exp_pc = redirect_addr & ~32'h3;
      if (imem_rsp_valid) pend = 0;
      else if (pend) pend_cnt--;
      if (req_hs) begin
        pend      = 1;
        pend_addr = imem_req_addr;
        pend_cnt  = (lat_rand ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
      end
      if (b_req_valid) b_addrs.push_back(b_req_addr);
      b_pend = b_req_valid;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    drv_rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i > 0) begin
        chk_eq("rst_req_valid", imem_req_valid, 1'b0);
        chk_eq("rst_inst_valid", inst_valid, 1'b0);
        chk_eq("rst_inst_data", inst_data, 32'h0);
        chk_eq("rst_inst_pc", inst_pc, 32'h0);
        chk_eq("rst_fetch_pc", fetch_pc, RST_A);
      end
    end
    drv_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held_data;
    bit          got;

    // Sequential fetch, always-ready memory, one-cycle response.
    do_reset(3);
    hs_cyc.delete();
    tick();
    chk_eq("first_req_valid", imem_req_valid, 1'b1);
    chk_eq("first_req_addr", imem_req_addr, RST_A);
    repeat (8) tick();
    chk_eq("seq_count", hs_cyc.size(), 3);
    chk_eq("seq_gap0", hs_cyc[1] - hs_cyc[0], 3);
    chk_eq("seq_gap1", hs_cyc[2] - hs_cyc[1], 3);
    chk_eq("wrap_count", b_addrs.size() >= 2, 1'b1);
    chk_eq("wrap_first", b_addrs[0], RST_B);
    chk_eq("wrap_second", b_addrs[1], 32'h0);

    // Decode back-pressure holds the buffer and blocks fetch.
    do_reset(2);
    drv_irdy = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = inst_valid;
    end
    chk_eq("hold_got_inst", got, 1'b1);
    chk_eq("hold_inst_pc", inst_pc, 32'h0);
    held_data = inst_data;
    repeat (4) begin
      tick();
      chk_eq("hold_req_valid", imem_req_valid, 1'b0);
      chk_eq("hold_inst_valid", inst_valid, 1'b1);
      chk_eq("hold_inst_data", inst_data, held_data);
    end
    drv_irdy = 1'b1;
    tick();
    tick();
    chk_eq("release_req_valid", imem_req_valid, 1'b1);
    chk_eq("release_req_addr", imem_req_addr, 32'h4);

    // Redirect while waiting: outstanding response must be squashed.
    do_reset(2);
    lat_cfg = 3;
    tick();
    drv_redir = 1'b1;
    drv_raddr = 32'h100;
    tick();
    drv_redir = 1'b0;
    tick();
    chk_eq("squash_state", dut.state_q, SQUASH);
    chk_eq("squash_req_valid", imem_req_valid, 1'b0);
    lat_cfg = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = imem_req_valid;
    end
    chk_eq("squash_got_req", got, 1'b1);
    chk_eq("squash_req_addr", imem_req_addr, 32'h100);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = inst_valid;
    end
    chk_eq("squash_got_inst", got, 1'b1);
    chk_eq("squash_inst_pc", inst_pc, 32'h100);

    // Redirect coincident with the response: response dropped, target aligned.
    do_reset(2);
    tick();
    drv_redir = 1'b1;
    drv_raddr = 32'h203;
    tick();
    drv_redir = 1'b0;
    tick();
    chk_eq("coinc_req_valid", imem_req_valid, 1'b1);
    chk_eq("coinc_req_addr", imem_req_addr, 32'h200);
    chk_eq("coinc_inst_valid", inst_valid, 1'b0);
    repeat (4) tick();

    // Reset while a request is outstanding.
    do_reset(2);
    lat_cfg = 3;
    tick();
    tick();
    do_reset(2);
    lat_cfg = 1;
    tick();
    chk_eq("rst_wait_inst_valid", inst_valid, 1'b0);
    chk_eq("rst_wait_req_valid", imem_req_valid, 1'b1);
    chk_eq("rst_wait_req_addr", imem_req_addr, RST_A);
    repeat (6) tick();

    // Random traffic against the stream model.
    n_deliv    = 0;
    rdy_rand   = 1;
    irdy_rand  = 1;
    redir_rand = 1;
    lat_rand   = 1;
    rst_rand   = 1;
    repeat (4000) tick();
    chk_eq("random_progress", n_deliv >= 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
